// File: rtl/prog_clkgen_multi.sv
// NUM_CH-channel programmable clock/pulse generator: per-channel phase/ton/toff in clk cycles,
// shadow config written through a valid/ready port and applied at period boundaries.
module prog_clkgen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH):0]   cfg_ch,
  input  logic [CNT_W-1:0]          cfg_phase,
  input  logic [CNT_W-1:0]          cfg_ton,
  input  logic [CNT_W-1:0]          cfg_toff,
  output logic                      cfg_err,
  input  logic [NUM_CH-1:0]         en,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         rise_stb,
  output logic [NUM_CH-1:0]         active
);

  localparam int CH_W = $clog2(NUM_CH) + 1;
  localparam logic [CH_W-1:0]  LP_NUM_CH = CH_W'(NUM_CH);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PHASE = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  logic r_cfg_ready;
  logic r_cfg_err;
  logic w_cfg_acc;

  assign w_cfg_acc = cfg_valid && r_cfg_ready;
  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= w_cfg_acc && (cfg_ch >= LP_NUM_CH);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]       r_state, w_nstate;
    logic [CNT_W-1:0] r_cnt, w_ncnt;
    logic [CNT_W-1:0] r_sh_phase, r_sh_ton, r_sh_toff;
    logic [CNT_W-1:0] r_lv_ton, r_lv_toff;
    logic [CNT_W-1:0] w_t, w_f;
    logic             w_load, w_start, w_wr, w_clk;
    logic             r_clk_out, r_rise;

    assign w_wr = w_cfg_acc && (cfg_ch == CH_W'(g));

    // Every period starts through w_start so ton=0/toff=0 degenerate cases share one path:
    // ton=0 parks in LOW, toff=0 re-enters HIGH at its own boundary.
    always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_load   = 1'b0;
      w_start  = 1'b0;
      w_t      = r_lv_ton;
      w_f      = r_lv_toff;
      if (!en[g]) begin
        w_nstate = ST_IDLE;
        w_ncnt   = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_load = 1'b1;
            w_t    = r_sh_ton;
            w_f    = r_sh_toff;
            if (r_sh_phase != '0) begin
              w_nstate = ST_PHASE;
              w_ncnt   = r_sh_phase;
            end else begin
              w_start = 1'b1;
            end
          end
          ST_PHASE: begin
            if (r_cnt <= LP_ONE) w_start = 1'b1;
            else                 w_ncnt  = r_cnt - LP_ONE;
          end
          ST_HIGH: begin
            if (r_cnt > LP_ONE) begin
              w_ncnt = r_cnt - LP_ONE;
            end else if (r_lv_toff != '0) begin
              w_nstate = ST_LOW;
              w_ncnt   = r_lv_toff;
            end else begin
              w_load  = 1'b1;
              w_start = 1'b1;
              w_t     = r_sh_ton;
              w_f     = r_sh_toff;
            end
          end
          default: begin
            if (r_cnt > LP_ONE) begin
              w_ncnt = r_cnt - LP_ONE;
            end else begin
              w_load  = 1'b1;
              w_start = 1'b1;
              w_t     = r_sh_ton;
              w_f     = r_sh_toff;
            end
          end
        endcase
        if (w_start) begin
          if (w_t != '0) begin
            w_nstate = ST_HIGH;
            w_ncnt   = w_t;
          end else begin
            w_nstate = ST_LOW;
            w_ncnt   = w_f;
          end
        end
      end
    end

    // Output reflects the state held before the edge, giving the one-cycle E+1 latency.
    assign w_clk = en[g] && (r_state == ST_HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_sh_phase <= '0;
        r_sh_ton   <= LP_ONE;
        r_sh_toff  <= LP_ONE;
        r_lv_ton   <= LP_ONE;
        r_lv_toff  <= LP_ONE;
        r_clk_out  <= 1'b0;
        r_rise     <= 1'b0;
      end else begin
        r_state   <= w_nstate;
        r_cnt     <= w_ncnt;
        r_clk_out <= w_clk;
        r_rise    <= w_clk && !r_clk_out;
        if (w_wr) begin
          r_sh_phase <= cfg_phase;
          r_sh_ton   <= cfg_ton;
          r_sh_toff  <= cfg_toff;
        end
        if (w_load) begin
          r_lv_ton  <= r_sh_ton;
          r_lv_toff <= r_sh_toff;
        end
      end
    end

    assign clk_out[g]  = r_clk_out;
    assign rise_stb[g] = r_rise;
    assign active[g]   = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_prog_clkgen_multi.sv
// Self-checking bench for prog_clkgen_multi: expected rise cycles are queued when a channel
// is configured/enabled and popped as rise_stb pulses appear; levels checked against a waveform model.
module tb_prog_clkgen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic [CNT_W-1:0]  cfg_ton = '0;
  logic [CNT_W-1:0]  cfg_toff = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] en = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_stb;
  logic [NUM_CH-1:0] active;

  prog_clkgen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_phase(cfg_phase), .cfg_ton(cfg_ton), .cfg_toff(cfg_toff),
    .cfg_err(cfg_err), .en(en), .clk_out(clk_out), .rise_stb(rise_stb), .active(active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Key = cycle*16 + channel; queue kept sorted so same-cycle rises pop in channel order.
  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rise_stb[ch]) begin
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("rise", cyc * 16 + ch, e);
      end
    end
  end

  function automatic int exp_lvl(input int c, input int st, input int ton, input int toff);
    if (c < st || ton == 0) return 0;
    if (toff == 0) return 1;
    return (((c - st) % (ton + toff)) < ton) ? 1 : 0;
  endfunction

  task automatic push_rises(input int ch, input int st, input int ton, input int toff,
                            input int last);
    if (ton > 0) begin
      for (int r = st; r <= last; r += ton + toff) begin
        exp_q.push_back(r * 16 + ch);
        if (toff == 0) break;
      end
    end
    exp_q.sort();
  endtask

  task automatic cfg_write(input int ch, input int p, input int t, input int f);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_phase = CNT_W'(p);
    cfg_ton   = CNT_W'(t);
    cfg_toff  = CNT_W'(f);
    chk("cfg_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_err_ok", cfg_err, 0);
  endtask

  // Must be entered at a negedge; enables ch for ncyc cycles then drops en.
  task automatic run_ch(input int ch, input int p, input int t, input int f,
                        input int ncyc, input bit wr);
    int k, st;
    if (wr) cfg_write(ch, p, t, f);
    en[ch] = 1'b1;
    k  = cyc;
    st = k + 2 + p;
    push_rises(ch, st, t, f, k + ncyc);
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      chk("lvl", clk_out[ch], exp_lvl(cyc, st, t, f));
      chk("active", active[ch], 1);
    end
    en[ch] = 1'b0;
    @(negedge clk);
    chk("off_lvl", clk_out[ch], 0);
    chk("off_active", active[ch], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e;
    repeat (3) @(negedge clk);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_active", active, 0);
    chk("rst_rise", rise_stb, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_up", cfg_ready, 1);

    // 1: ch0 {2,3,2}, rises every 5 cycles starting E+3
    run_ch(0, 2, 3, 2, 22, 1'b1);
    repeat (2) @(negedge clk);

    // 2: ch1 {0,4,4}, rewrite to {0,1,1} mid-HIGH; new timing only after the boundary
    cfg_write(1, 0, 4, 4);
    en[1] = 1'b1;
    k = cyc;
    e = k + 1;
    exp_q.push_back((e + 1) * 16 + 1);
    push_rises(1, e + 9, 1, 1, k + 20);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cyc < e + 9) chk("t2_lvl", clk_out[1], exp_lvl(cyc, e + 1, 4, 4));
      else             chk("t2_lvl", clk_out[1], exp_lvl(cyc, e + 9, 1, 1));
      if (cyc == e + 2) begin
        cfg_valid = 1'b1; cfg_ch = 3'd1;
        cfg_phase = '0; cfg_ton = CNT_W'(1); cfg_toff = CNT_W'(1);
      end else begin
        cfg_valid = 1'b0;
      end
    end
    en[1] = 1'b0;
    @(negedge clk);
    chk("t2_off", clk_out[1], 0);

    // 3+4: ch2 ton=0, ch3 toff=0; out-of-range write in the middle
    cfg_write(2, 1, 0, 3);
    cfg_write(3, 2, 5, 0);
    en[2] = 1'b1;
    en[3] = 1'b1;
    k = cyc;
    e = k + 1;
    exp_q.push_back((e + 3) * 16 + 3);
    exp_q.sort();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("t3_lvl2", clk_out[2], exp_lvl(cyc, e + 2, 0, 3));
      chk("t3_lvl3", clk_out[3], exp_lvl(cyc, e + 3, 5, 0));
      chk("t3_active", active[3:2], 3);
      if (i == 5) begin
        cfg_valid = 1'b1; cfg_ch = 3'(NUM_CH);
        cfg_phase = '0; cfg_ton = CNT_W'(1); cfg_toff = CNT_W'(1);
      end else if (i == 6) begin
        chk("t4_err_pulse", cfg_err, 1);
        cfg_valid = 1'b0;
      end else if (i == 7) begin
        chk("t4_err_clear", cfg_err, 0);
      end
    end
    en[3:2] = 2'b00;
    @(negedge clk);
    chk("t3_off", clk_out[3:2], 0);

    // 5: ch0 keeps {2,3,2}; drop en mid-HIGH, then re-enable repeats the phase
    run_ch(0, 2, 3, 2, 4, 1'b0);
    repeat (3) @(negedge clk);
    run_ch(0, 2, 3, 2, 12, 1'b0);

    // 6: async reset mid-HIGH, then defaults {0,1,1} on every channel
    cfg_write(1, 0, 6, 2);
    en[1] = 1'b1;
    k = cyc;
    e = k + 1;
    exp_q.push_back((e + 1) * 16 + 1);
    exp_q.sort();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t6_lvl", clk_out[1], exp_lvl(cyc, e + 1, 6, 2));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_clk", clk_out, 0);
    chk("t6_async_act", active, 0);
    chk("t6_async_rdy", cfg_ready, 0);
    en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", cfg_ready, 1);
    en = '1;
    k = cyc;
    for (int ch = 0; ch < NUM_CH; ch++) push_rises(ch, k + 2, 1, 1, k + 10);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++)
        chk("t6_dflt", clk_out[ch], exp_lvl(cyc, k + 2, 1, 1));
    end
    en = '0;
    repeat (2) @(negedge clk);
    chk("q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
